// File: rtl/branch_ctrl.sv
// Branch/jump control: holds the PC and the N/Z status flags, decodes the branch status
// from the decoder and selects the next PC (relative, register, or memory-indirect target).
module branch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  status,
    input  logic        pc_hold,
    input  logic        flag_we,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic [31:0] imm_ext,
    input  logic [31:0] rs_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        taken,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        flag_n,
    output logic        flag_z
);

    typedef enum logic [2:0] {
        OpNone = 3'b000,
        OpBmn  = 3'b001,
        OpBrz  = 3'b010,
        OpBz   = 3'b011,
        OpJmor = 3'b100,
        OpJalm = 3'b101,
        OpRsvd = 3'b110,
        OpBeq  = 3'b111
    } op_e;

    logic [31:0] pc_q, pc_d;
    logic        flag_n_q, flag_z_q;
    logic [31:0] btgt;
    logic [31:0] target;
    logic        link_op;
    op_e         op;

    assign op        = op_e'(status);
    assign pc_plus4  = pc_q + 32'd4;
    assign btgt      = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign link_data = pc_plus4;

    always_comb begin
        taken   = 1'b0;
        target  = pc_plus4;
        link_op = 1'b0;
        case (op)
            OpBeq: begin
                taken  = alu_zero;
                target = btgt;
            end
            OpBmn: begin
                taken  = flag_n_q;
                target = mem_rdata;
            end
            OpBrz: begin
                taken  = flag_z_q;
                target = rs_data;
            end
            OpBz: begin
                taken  = flag_z_q;
                target = btgt;
            end
            OpJmor: begin
                taken  = 1'b1;
                target = mem_rdata;
            end
            OpJalm: begin
                taken   = 1'b1;
                target  = mem_rdata;
                link_op = 1'b1;
            end
            default: begin
                taken   = 1'b0;
                target  = pc_plus4;
                link_op = 1'b0;
            end
        endcase
    end

    // Untaken conditions fall back to pc_plus4; every PC load is word-aligned.
    assign pc_d    = (taken ? target : pc_plus4) & ~32'h3;
    assign link_we = link_op & ~pc_hold & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC & ~32'h3;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else if (!pc_hold) begin
            pc_q <= pc_d;
            if (flag_we) begin
                flag_z_q <= (alu_result == 32'd0);
                flag_n_q <= alu_result[31];
            end
        end
    end

    assign pc     = pc_q;
    assign flag_n = flag_n_q;
    assign flag_z = flag_z_q;

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 status  in  3  {status2,status1,status0} from decoder: 000 none, 111 beq, 001 bmn, 010 brz, 011 bz, 100 jmor, 101 jalm, 110 reserved.
REQ-005 pc_hold  in  1  stall; freezes PC and flags.
REQ-006 flag_we  in  1  update N/Z flags from alu_result this cycle.
REQ-007 alu_result  in  32  current ALU output.
REQ-008 alu_zero  in  1  current ALU zero (beq compare).
REQ-009 imm_ext  in  32  sign-extended immediate (word offset).
REQ-010 rs_data  in  32  register-file rs value.
REQ-011 mem_rdata  in  32  data-memory read data, valid same cycle.
REQ-012 pc  out  32  current PC register.
REQ-013 pc_plus4  out  32  pc + 4, modulo 2^32.
REQ-014 taken  out  1  next PC is not pc_plus4.
REQ-015 link_we  out  1  write link value to rt (jalm).
REQ-016 link_data  out  32  equals pc_plus4.
REQ-017 flag_n, flag_z  out  1 each  registered status flags.

Function
REQ-018 Branch target btgt = pc_plus4 + (imm_ext << 2), 32-bit wrap, overflow ignored.
REQ-019 beq: taken = alu_zero; next = btgt.
REQ-020 bmn: taken = flag_n; next = mem_rdata.
REQ-021 brz: taken = flag_z; next = rs_data.
REQ-022 bz: taken = flag_z; next = btgt.
REQ-023 jmor: taken = 1; next = mem_rdata.
REQ-024 jalm: taken = 1; next = mem_rdata; link_we = 1.
REQ-025 none/reserved: taken = 0; next = pc_plus4; link_we = 0.
REQ-026 Every next-PC value has bits [1:0] forced to 00 before loading.
REQ-027 Condition evaluation uses flag values registered before the current edge; a flag_we in the same cycle affects only subsequent instructions.
REQ-028 On edge with flag_we=1 and pc_hold=0: flag_z <= (alu_result == 0), flag_n <= alu_result[31]; otherwise flags hold.
REQ-029 On edge with pc_hold=0: pc <= next; pc_hold=1: pc, flags unchanged.
REQ-030 link_we is forced 0 while pc_hold=1; taken still reflects the decode (combinational).
REQ-031 taken, link_we, pc_plus4, link_data are combinational from current state and inputs; branch latency one cycle (target visible on pc after the edge).
REQ-032 pc = 32'hFFFF_FFFC with no branch wraps to 32'h0000_0000.

Reset
REQ-033 reset_n low asynchronously forces pc = RESET_PC with bits [1:0] cleared, flag_n = 0, flag_z = 0, regardless of clk.
REQ-034 During reset link_we = 0 and taken reflects status with cleared flags.
REQ-035 First edge after reset_n rises updates state normally; reset asserted mid-branch discards the pending target.

Verification
REQ-036 Reset, status=000 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; flags 0.
REQ-037 pc=0x100, beq, alu_zero=1, imm_ext=0xFFFF_FFFE -> taken=1, next pc 0xFC; alu_zero=0 -> pc 0x104.
REQ-038 flag_we with alu_result=0x8000_0000, then bmn with mem_rdata=0x2003 -> flag_n=1, pc 0x2000; same bmn with flag_n=0 -> pc_plus4.
REQ-039 brz with flag_we=1, alu_result=0 in same cycle and flag_z previously 0 -> not taken; next brz with rs_data=0x400 -> pc 0x400.
REQ-040 pc=0x50, jalm, mem_rdata=0x800 -> link_we=1, link_data 0x54, pc 0x800; repeat with pc_hold=1 -> link_we=0, pc stays 0x50.
REQ-041 Assert reset_n low between edges while status=jmor -> pc immediately RESET_PC, flags 0, no jump taken on next edge.
